// File: rtl/harmonic_sequencer.sv
// rtl/harmonic_sequencer.sv - per-sample harmonic scheduler sharing one SineLUT port, summing to one DAC word
// Optional feature macro: HARM_ROLLOFF_EN (weights harmonic h by 2^-floor(log2 h))
module harmonic_sequencer #(
  parameter int          NUM_HARM       = 8,
  parameter int          SAMPLERATE     = 48000,
  parameter int          SAMPLEINTERVAL = 1750,
  parameter int          OUT_SHIFT      = 3,
  parameter logic [7:0]  CHANNEL_CMD    = 8'b00110001
) (
  input  logic                fpga_clock,
  input  logic                reset,
  input  logic [15:0]         frequency,
  input  logic [NUM_HARM-1:0] harm_en,
  output logic [10:0]         lut_addr,
  input  logic [15:0]         lut_value,
  output logic [23:0]         dac_data,
  output logic                dac_send,
  output logic                busy
);

  localparam int AW  = 16 + $clog2(NUM_HARM + 1);
  localparam int TW  = (SAMPLEINTERVAL > 1) ? $clog2(SAMPLEINTERVAL) : 1;
  localparam int HIW = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam logic [16:0]          SR17 = 17'(SAMPLERATE);
  localparam logic signed [AW-1:0] SMAX = AW'(32767);
  localparam logic signed [AW-1:0] SMIN = AW'(-32768);

  typedef enum logic [2:0] {IDLE, PHASE, ADDR, WAIT, ACC, SEND} state_t;

  state_t                state, state_n;
  logic [TW-1:0]         timer;
  logic                  tick;
  logic [15:0]           freq_l;
  logic [15:0]           inc;
  logic [15:0]           freq_red;
  logic [15:0]           phase [NUM_HARM];
  logic [HIW-1:0]        hi;
  logic                  last;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  shifted;
  logic [15:0]           code;

  // Modular add for values already below SAMPLERATE: one conditional subtract suffices.
  function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SR17) s = s - SR17;
    return s[15:0];
  endfunction

`ifdef HARM_ROLLOFF_EN
  function automatic int flog2(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 5; i++) if (v >= (1 << i)) r = i;
    return r;
  endfunction
`endif

  assign tick     = (timer == '0);
  assign last     = (hi == HIW'(NUM_HARM - 1));
  assign busy     = (state != IDLE);
  assign freq_red = (frequency >= 16'(SAMPLERATE)) ? frequency - 16'(SAMPLERATE) : frequency;

  // Free-running sample-period timer; the tick is the zero count.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset)                                timer <= '0;
    else if (timer == TW'(SAMPLEINTERVAL - 1)) timer <= '0;
    else                                      timer <= timer + 1'b1;
  end

  // Per-harmonic term and saturated output code.
  always_comb begin
`ifdef HARM_ROLLOFF_EN
    term = AW'($signed(lut_value)) >>> flog2(int'(hi) + 1);
`else
    term = AW'($signed(lut_value));
`endif
    shifted = acc >>> OUT_SHIFT;
    if (shifted > SMAX)      code = 16'h7FFF;
    else if (shifted < SMIN) code = 16'h8000;
    else                     code = shifted[15:0];
  end

  // State register.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state sequencing: four cycles per harmonic, then one send cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = PHASE;
      PHASE:   state_n = ADDR;
      ADDR:    state_n = WAIT;
      WAIT:    state_n = ACC;
      ACC:     state_n = last ? SEND : PHASE;
      SEND:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: phase/increment update, LUT addressing, accumulation and DAC word.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      freq_l   <= '0;
      inc      <= '0;
      hi       <= '0;
      acc      <= '0;
      lut_addr <= '0;
      dac_data <= '0;
      dac_send <= 1'b0;
      for (int i = 0; i < NUM_HARM; i++) phase[i] <= '0;
    end else begin
      dac_send <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          freq_l <= freq_red;
          inc    <= freq_red;
          hi     <= '0;
          acc    <= '0;
        end
        PHASE: begin
          phase[hi] <= mod_add(phase[hi], inc);
          inc       <= mod_add(inc, freq_l);
        end
        ADDR: lut_addr <= phase[hi][15:5];
        ACC: begin
          if (harm_en[hi]) acc <= acc + term;
          if (!last)       hi  <= hi + 1'b1;
        end
        SEND: begin
          dac_data <= {CHANNEL_CMD, code ^ 16'h8000};
          dac_send <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// tb/tb_harmonic_sequencer.sv - directed self-checking bench for harmonic_sequencer
module tb_harmonic_sequencer;

  localparam int SI = 100;

  logic        fpga_clock;
  logic        reset;
  logic [15:0] frequency;
  logic [1:0]  harm_en_a;
  logic [7:0]  harm_en_b;
  logic [10:0] lut_addr_a, lut_addr_b;
  logic [15:0] lut_value_a, lut_value_b;
  logic [23:0] dac_data_a, dac_data_b;
  logic        dac_send_a, dac_send_b;
  logic        busy_a, busy_b;
  logic        b_force;
  logic [15:0] b_fval;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          a_addr [1:8];
  int          b_addr [1:8];
  logic [23:0] a_data, b_data;
  int          a_send_cnt, b_send_cnt;
  int          a_last, a_period;

  assign lut_value_a = {5'b0, lut_addr_a};
  assign lut_value_b = b_force ? b_fval : {5'b0, lut_addr_b};

  harmonic_sequencer #(.NUM_HARM(2), .SAMPLEINTERVAL(SI), .OUT_SHIFT(3)) u_a (
    .fpga_clock(fpga_clock), .reset(reset), .frequency(frequency), .harm_en(harm_en_a),
    .lut_addr(lut_addr_a), .lut_value(lut_value_a), .dac_data(dac_data_a),
    .dac_send(dac_send_a), .busy(busy_a));

  harmonic_sequencer #(.NUM_HARM(8), .SAMPLEINTERVAL(SI), .OUT_SHIFT(0)) u_b (
    .fpga_clock(fpga_clock), .reset(reset), .frequency(frequency), .harm_en(harm_en_b),
    .lut_addr(lut_addr_b), .lut_value(lut_value_b), .dac_data(dac_data_b),
    .dac_send(dac_send_b), .busy(busy_b));

  initial fpga_clock = 1'b0;
  always #5 fpga_clock = ~fpga_clock;

  always @(posedge fpga_clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge fpga_clock);
    reset = 1'b1;
    repeat (3) @(negedge fpga_clock);
    reset = 1'b0;
  endtask

  // Waits for the sample start, then logs each harmonic's LUT address (valid in its WAIT cycle)
  // and any DAC strobe. abort_off >= 0 asserts reset at that offset instead of finishing.
  task automatic run_sample(input int abort_off);
    int n;
    n = 0;
    a_data = '0; b_data = '0; a_send_cnt = 0; b_send_cnt = 0;
    for (int k = 1; k <= 8; k++) begin a_addr[k] = -1; b_addr[k] = -1; end
    @(negedge fpga_clock);
    while (!busy_a && n < 3 * SI) begin @(negedge fpga_clock); n++; end
    chk("tick_seen", {31'b0, busy_a}, 1);
    for (int o = 0; o <= 35; o++) begin
      if (o == abort_off) begin
        reset = 1'b1;
        #1;
        chk("abort_busy_b", {31'b0, busy_b}, 0);
        chk("abort_send_b", {31'b0, dac_send_b}, 0);
        return;
      end
      for (int k = 1; k <= 8; k++) begin
        if (o == 2 + 4 * (k - 1)) begin
          if (k <= 2) a_addr[k] = int'(lut_addr_a);
          b_addr[k] = int'(lut_addr_b);
        end
      end
      if (dac_send_a) begin
        a_data = dac_data_a; a_send_cnt++;
        a_period = cyc - a_last; a_last = cyc;
      end
      if (dac_send_b) begin b_data = dac_data_b; b_send_cnt++; end
      @(negedge fpga_clock);
    end
    chk("idle_busy_b", {31'b0, busy_b}, 0);
  endtask

  initial begin
    reset = 1'b1; frequency = 16'd1000; harm_en_a = 2'b11; harm_en_b = 8'h00;
    b_force = 1'b0; b_fval = 16'h0000; a_last = 0; a_period = 0;
    repeat (3) @(negedge fpga_clock);
    chk("rst_addr", {21'b0, lut_addr_a}, 0);
    chk("rst_data", {8'b0, dac_data_a}, 0);
    chk("rst_send", {31'b0, dac_send_a}, 0);
    chk("rst_busy", {31'b0, busy_b}, 0);
    reset = 1'b0;

    // Two harmonics at 1 kHz; B has everything disabled.
    run_sample(-1);
    chk("s1_a_h1", a_addr[1], 31);
    chk("s1_a_h2", a_addr[2], 62);
    chk("s1_a_data", {8'b0, a_data}, 24'h31800B);
    chk("s1_a_sends", a_send_cnt, 1);
    chk("s1_b_data_off", {8'b0, b_data}, 24'h318000);
    run_sample(-1);
    chk("s2_a_h1", a_addr[1], 62);
    chk("s2_a_h2", a_addr[2], 125);
    chk("s2_a_data", {8'b0, a_data}, 24'h318017);
    chk("s2_period", a_period, SI);
    for (int s = 3; s <= 10; s++) run_sample(-1);
    chk("s10_b_data_off", {8'b0, b_data}, 24'h318000);

    // Re-enable harmonic 2: phase kept advancing while disabled.
    harm_en_b = 8'b0000_0010;
    run_sample(-1);
    chk("s11_b_h1", b_addr[1], 343);
    chk("s11_b_h2", b_addr[2], 687);
    chk("s11_b_data", {8'b0, b_data}, 24'h3182AF);

    // Reset during WAIT of harmonic 3 aborts without a send.
    harm_en_b = 8'hFF;
    run_sample(10);
    repeat (4) begin
      @(negedge fpga_clock);
      chk("rst_hold_send", {31'b0, dac_send_b}, 0);
    end
    reset = 1'b0;
    run_sample(-1);
    chk("post_a_h1", a_addr[1], 31);
    chk("post_b_h1", b_addr[1], 31);
    chk("post_b_h3", b_addr[3], 93);
    chk("post_b_h8", b_addr[8], 250);
    chk("post_b_data", {8'b0, b_data}, 24'h318462);
    chk("post_b_sends", b_send_cnt, 1);

    // Near-modulus frequency walks downward.
    frequency = 16'd47000;
    do_reset();
    run_sample(-1);
    chk("f47k_s1_h1", a_addr[1], 1468);
    chk("f47k_s1_h2", a_addr[2], 1437);
    run_sample(-1);
    chk("f47k_s2_h1", a_addr[1], 1437);
    run_sample(-1);
    chk("f47k_s3_h1", a_addr[1], 1406);

    // Over-modulus frequency is reduced once.
    frequency = 16'd50000;
    do_reset();
    run_sample(-1);
    chk("f50k_h1", a_addr[1], 62);

    // Exact wrap to zero, plus saturation on the 8-harmonic instance.
    frequency = 16'd16000; b_force = 1'b1; b_fval = 16'h7FFF;
    do_reset();
    run_sample(-1);
    chk("f16k_s1_h1", a_addr[1], 500);
    chk("sat_pos", {8'b0, b_data}, 24'h31FFFF);
    b_fval = 16'h8000;
    run_sample(-1);
    chk("f16k_s2_h1", a_addr[1], 1000);
    chk("sat_neg", {8'b0, b_data}, 24'h310000);
    run_sample(-1);
    chk("f16k_s3_h1", a_addr[1], 0);
    chk("f16k_s3_h2", a_addr[2], 0);
    chk("f16k_s3_data", {8'b0, a_data}, 24'h318000);

    // Zero frequency: phases hold yet the DAC still receives a word each period.
    frequency = 16'd0; b_force = 1'b0;
    do_reset();
    run_sample(-1);
    run_sample(-1);
    chk("f0_h1", a_addr[1], 0);
    chk("f0_sends", a_send_cnt, 1);
    chk("f0_data", {8'b0, a_data}, 24'h318000);
    chk("f0_period", a_period, SI);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/harmonic_sequencer.md
Name: harmonic_sequencer

Overview:
Sample-rate scheduler for the additive oscillator. Once per sample period it walks NUM_HARM harmonic phase accumulators and time-shares the single SineLUT read port between them. It sums the returned sine values, then hands one 24-bit word to DAC_SPI_Out with a single-cycle send strobe. It sits between the ADC_SPI_In frequency control word and the SineLUT/DAC_SPI_Out pair. It replaces the hard-coded timer-slot sequencing in the top level.

Parameters:
NUM_HARM, 8, number of harmonics (1..16); harmonic h uses multiplier h
SAMPLERATE, 48000, phase modulus; the LUT has SAMPLERATE/32 = 1500 entries
SAMPLEINTERVAL, 1750, fpga_clock cycles per output sample (84 MHz / 48 kHz)
OUT_SHIFT, 3, arithmetic right shift applied to the sum before saturation
CHANNEL_CMD, 8'b00110001, DAC command byte (write to channel A)

Ports:
fpga_clock  in  1  system clock, 84 MHz
reset  in  1  asynchronous, active-high
frequency  in  16  fundamental in Hz; sampled only at the sample tick
harm_en  in  NUM_HARM  bit h-1 enables accumulation of harmonic h
lut_addr  out  11  SineLUT address (registered)
lut_value  in  16  signed SineLUT Q; valid 2 clocks after lut_addr changes
dac_data  out  24  {CHANNEL_CMD, code}
dac_send  out  1  single-cycle strobe, dac_data valid on the same cycle
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-high. Clock is fpga_clock.
- Reset values: lut_addr=0, dac_data=0, dac_send=0, busy=0. All phases, the timer, the accumulator and the latched frequency clear to 0. State goes to IDLE.
- Reset mid-sequence aborts the sequence. No dac_send is issued.
- Timer counts 0..SAMPLEINTERVAL-1, then wraps. Tick occurs on count==0.
- Tick in IDLE:
  - freq_l <= frequency, reduced to frequency-SAMPLERATE if frequency >= SAMPLERATE (one subtract is sufficient for 16-bit input).
  - inc <= reduced frequency, h <= 1, acc <= 0.
  - Go to PHASE.
- PHASE:
  - phase[h] <= (phase[h]+inc) mod SAMPLERATE, computed as a 17-bit sum with a conditional subtract.
  - inc <= (inc+freq_l) mod SAMPLERATE, using the same rule.
  - Go to ADDR.
- ADDR: lut_addr <= phase[h] >> 5 (the post-update phase). Go to WAIT.
- WAIT: one cycle. Go to ACC.
- ACC:
  - If harm_en[h-1] is set, acc <= acc + sign-extended lut_value.
  - Disabled harmonics still advance their phase, keeping them coherent when re-enabled.
  - If h==NUM_HARM, go to SEND. Otherwise h <= h+1 and go to PHASE.
  - Cost: 4 cycles per harmonic.
- SEND:
  - s = acc >>> OUT_SHIFT, saturated to the range -32768..32767.
  - dac_data <= {CHANNEL_CMD, s ^ 16'h8000} (offset binary).
  - dac_send <= 1 for exactly one cycle.
  - Go to IDLE.
- Accumulator width: 16 + ceil(log2(NUM_HARM+1)) bits, signed.
- A tick arriving while busy is ignored. This cannot occur when 4*NUM_HARM+2 < SAMPLEINTERVAL, which is required.
- frequency==0: phases hold, lut_addr stays constant, dac_send still pulses every period.
- Changes to frequency between ticks have no effect until the next tick.
- Phase exactly equal to SAMPLERATE-inc wraps to 0, giving lut_addr 0.

Optional Feature:
HARM_ROLLOFF_EN
- Defined: each accumulated term is lut_value >>> floor(log2(h)), an approximate 1/h sawtooth roll-off.
- Undefined: all enabled harmonics are summed at equal weight, exactly as described in Behaviour.

Test Plan:
1. NUM_HARM=1, frequency=1000, harm_en=1 -> first tick gives lut_addr=31 (phase 1000); second tick gives lut_addr=62. dac_send pulses once every 1750 clocks, dac_data[23:16]=8'h31.
2. NUM_HARM=2, frequency=1000 -> first sample issues lut_addr 31 then 62. Second sample issues 62 then 125 (phases 2000 and 4000).
3. NUM_HARM=1, frequency=47000 -> phase sequence 47000, 46000, 45000, giving lut_addr 1468, 1437, 1406. frequency=50000 -> reduced to 2000, first lut_addr=62.
4. Force lut_value=16'h7FFF, NUM_HARM=8, OUT_SHIFT=0, all enabled -> code saturates to 32767, dac_data[15:0]=16'hFFFF. With lut_value=16'h8000 -> dac_data[15:0]=16'h0000.
5. harm_en=0 with frequency=1000 -> dac_data[15:0]=16'h8000. Re-enabling harmonic 2 after 10 samples gives lut_addr=(20000*2... i.e. phase 2000*11 mod 48000=22000) >> 5 = 687 for harmonic 2.
6. Assert reset during WAIT of harmonic 3 -> no dac_send, busy=0 immediately. After release the first sample matches the scenario 1/2 values from zero phase.
